// File: rtl/lbist_pkg.sv
// Shared types, defaults and result-recording helper for the LBIST multi-channel controller.
package lbist_pkg;

  localparam int unsigned N_CH_DEF    = 4;
  localparam int unsigned CNT_W_DEF   = 12;
  localparam int unsigned RST_CYC_DEF = 2;
  localparam int unsigned TO_CYC_DEF  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_CMP,
    S_WAIT,
    S_DONE
  } state_t;

  // to_fi selects fi_ok_vec (1) or pass_vec (0); value is the bit to store.
  typedef struct packed {
    logic to_fi;
    logic value;
  } rec_t;

  // A timeout (no valid) records a failure in whichever vector is active.
  function automatic rec_t record_result(input logic fi_flag,
                                         input logic got_valid,
                                         input logic ora_pass);
    rec_t r;
    r.to_fi = fi_flag;
    if (!got_valid)
      r.value = 1'b0;
    else if (fi_flag)
      r.value = ~ora_pass;
    else
      r.value = ora_pass;
    return r;
  endfunction

endpackage

// File: rtl/lbist_multi_controller_if.sv
// Request/result and TPG/FIC/ORA signal bundle of the LBIST multi-channel controller.
interface lbist_multi_controller_if
  import lbist_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             start;
  logic             mode_fi;
  logic [CNT_W-1:0] pat_count;
  logic             tpg_end;
  logic             ora_valid;
  logic             ora_pass;
  logic             cut_rst;
  logic             tpg_rst;
  logic             tpg_en;
  logic             fic_inj;
  logic             ora_cmp;
  logic [CH_W-1:0]  ch_sel;
  logic             busy;
  logic             done;
  logic [N_CH-1:0]  pass_vec;
  logic [N_CH-1:0]  fi_ok_vec;

  modport master (
    input  start, mode_fi, pat_count, tpg_end, ora_valid, ora_pass,
    output cut_rst, tpg_rst, tpg_en, fic_inj, ora_cmp, ch_sel,
           busy, done, pass_vec, fi_ok_vec
  );

  modport slave (
    output start, mode_fi, pat_count, tpg_end, ora_valid, ora_pass,
    input  cut_rst, tpg_rst, tpg_en, fic_inj, ora_cmp, ch_sel,
           busy, done, pass_vec, fi_ok_vec
  );

endinterface

// File: rtl/lbist_phase_counter.sv
// Loadable down-counter with a terminal flag; stops at zero.
module lbist_phase_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Load has priority over counting; never decrements past zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/lbist_multi_controller.sv
// LBIST sequencer: per channel resets CUT/TPG, runs patterns, strobes the ORA and records results.
module lbist_multi_controller
  import lbist_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned RST_CYC = RST_CYC_DEF,
  parameter int unsigned TO_CYC  = TO_CYC_DEF,
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  lbist_multi_controller_if.master  bus
);

  localparam int unsigned RW = $clog2(RST_CYC + 1);
  localparam int unsigned TW = $clog2(TO_CYC + 1);
  localparam logic [RW-1:0]   RST_LOAD = RW'(RST_CYC - 1);
  localparam logic [TW-1:0]   TO_LOAD  = TW'(TO_CYC - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

  state_t           state;
  logic             cut_rst, tpg_rst, tpg_en, fic_inj, ora_cmp, busy, done;
  logic [CH_W-1:0]  ch_sel;
  logic [N_CH-1:0]  pass_vec, fi_ok_vec;
  logic             fi_flag, mode_fi_l;
  logic [CNT_W-1:0] pat_lim, pat_cnt;
  logic             rst_tc, to_tc;
  rec_t             rec;

  // Counters reload continuously outside their phase, so they hold the full
  // count on the first cycle of RESET/WAIT without an explicit load strobe.
  lbist_phase_counter #(.W(RW)) u_rst_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (state != S_RESET),
    .load_val (RST_LOAD),
    .en       (state == S_RESET),
    .tc       (rst_tc)
  );

  lbist_phase_counter #(.W(TW)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (state != S_WAIT),
    .load_val (TO_LOAD),
    .en       (state == S_WAIT),
    .tc       (to_tc)
  );

  // Result to record when WAIT resolves (valid response or timeout).
  always_comb begin
    rec = record_result(fi_flag, bus.ora_valid, bus.ora_pass);
  end

  // Main sequencer; outputs are set on the edge that enters each state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cut_rst   <= 1'b1;
      tpg_rst   <= 1'b1;
      tpg_en    <= 1'b0;
      fic_inj   <= 1'b0;
      ora_cmp   <= 1'b0;
      ch_sel    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_vec  <= '0;
      fi_ok_vec <= '0;
      fi_flag   <= 1'b0;
      mode_fi_l <= 1'b0;
      pat_lim   <= '0;
      pat_cnt   <= '0;
    end else begin
      done    <= 1'b0;
      ora_cmp <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cut_rst <= 1'b0;
          tpg_rst <= 1'b0;
          if (bus.start) begin
            mode_fi_l <= bus.mode_fi;
            pat_lim   <= (bus.pat_count == '0) ? '0 : bus.pat_count - CNT_W'(1);
            pass_vec  <= '0;
            fi_ok_vec <= '0;
            ch_sel    <= '0;
            fi_flag   <= 1'b0;
            busy      <= 1'b1;
            cut_rst   <= 1'b1;
            tpg_rst   <= 1'b1;
            state     <= S_RESET;
          end
        end
        S_RESET: begin
          if (rst_tc) begin
            cut_rst <= 1'b0;
            tpg_rst <= 1'b0;
            tpg_en  <= 1'b1;
            fic_inj <= fi_flag;
            pat_cnt <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if ((pat_cnt == pat_lim) || bus.tpg_end) begin
            tpg_en  <= 1'b0;
            fic_inj <= 1'b0;
            ora_cmp <= 1'b1;
            state   <= S_CMP;
          end else begin
            pat_cnt <= pat_cnt + CNT_W'(1);
          end
        end
        S_CMP: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ora_valid || to_tc) begin
            if (rec.to_fi)
              fi_ok_vec[ch_sel] <= rec.value;
            else
              pass_vec[ch_sel] <= rec.value;
            if (mode_fi_l && !fi_flag) begin
              fi_flag <= 1'b1;
              cut_rst <= 1'b1;
              tpg_rst <= 1'b1;
              state   <= S_RESET;
            end else begin
              fi_flag <= 1'b0;
              if (ch_sel == LAST_CH) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                ch_sel  <= ch_sel + CH_W'(1);
                cut_rst <= 1'b1;
                tpg_rst <= 1'b1;
                state   <= S_RESET;
              end
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cut_rst   = cut_rst;
  assign bus.tpg_rst   = tpg_rst;
  assign bus.tpg_en    = tpg_en;
  assign bus.fic_inj   = fic_inj;
  assign bus.ora_cmp   = ora_cmp;
  assign bus.ch_sel    = ch_sel;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass_vec  = pass_vec;
  assign bus.fi_ok_vec = fi_ok_vec;

endmodule

// File: tb/tb_lbist_multi_controller.sv
// Directed bench for lbist_multi_controller with a run/result scoreboard and an ORA/TPG responder.
module tb_lbist_multi_controller;
  import lbist_pkg::*;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned CNT_W   = 12;
  localparam int unsigned RST_CYC = 2;
  localparam int unsigned TO_CYC  = 64;
  localparam int          ORA_LAT = 3;

  typedef struct {
    int ch;
    bit fi;
    int npat;
    int wlen;
  } run_t;

  typedef struct {
    logic [N_CH-1:0] pass;
    logic [N_CH-1:0] fi_ok;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lbist_multi_controller_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  lbist_multi_controller #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .RST_CYC (RST_CYC),
    .TO_CYC  (TO_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  run_t run_q[$];
  res_t res_q[$];

  // responder configuration, written by the main sequence while idle
  logic [N_CH-1:0] ch_good = '1;
  bit              ora_on  = 1'b1;
  int              end_at  = 0;

  int done_cnt = 0;
  int stray_fi = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_runs(input bit fi, input int npat, input int wlen);
    for (int c = 0; c < int'(N_CH); c++) begin
      run_q.push_back('{ch: c, fi: 1'b0, npat: npat, wlen: wlen});
      if (fi) run_q.push_back('{ch: c, fi: 1'b1, npat: npat, wlen: wlen});
    end
  endtask

  task automatic start_test(input bit fi, input int pat);
    bus.start     = 1'b1;
    bus.mode_fi   = fi;
    bus.pat_count = CNT_W'(pat);
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_cut_rst", 32'(bus.cut_rst), 32'd1);
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_test(input string tag, input int done_before);
    bit seen;
    wait_done(seen);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt - done_before), 32'd1);
    check({tag, "_runs_left"}, 32'(run_q.size()), 32'd0);
    check({tag, "_results_left"}, 32'(res_q.size()), 32'd0);
  endtask

  // Environment: counts RUN/RESET cycles, answers compare strobes, injects
  // tpg_end, and compares each completed run and each done against the scoreboard.
  initial begin
    int   en_cnt, rcnt, trcnt, ora_cnt, wcnt;
    bit   fi_seen, cur_fi, pending;
    int   exp_wlen;
    run_t r;
    res_t e;
    en_cnt = 0; rcnt = 0; trcnt = 0; ora_cnt = 0; wcnt = 0;
    fi_seen = 1'b0; cur_fi = 1'b0; pending = 1'b0; exp_wlen = 0;
    bus.tpg_end   = 1'b0;
    bus.ora_valid = 1'b0;
    bus.ora_pass  = 1'b0;
    forever begin
      @(negedge clk);
      bus.ora_valid = 1'b0;
      bus.ora_pass  = 1'b0;
      bus.tpg_end   = 1'b0;
      if (bus.fic_inj && !bus.tpg_en) stray_fi++;
      if (!bus.busy) begin
        en_cnt = 0; rcnt = 0; trcnt = 0; ora_cnt = 0;
        fi_seen = 1'b0; pending = 1'b0;
      end else begin
        if (bus.cut_rst) rcnt++;
        if (bus.tpg_rst) trcnt++;
        if (pending) begin
          wcnt++;
          if (bus.cut_rst || bus.done) begin
            check("wait_len", 32'(wcnt), 32'(exp_wlen));
            pending = 1'b0;
          end
        end
        if (bus.tpg_en) begin
          en_cnt++;
          if (bus.fic_inj) fi_seen = 1'b1;
          if (end_at != 0 && en_cnt == end_at) bus.tpg_end = 1'b1;
        end
        if (bus.ora_cmp) begin
          check("run_expected", 32'(run_q.size() != 0), 32'd1);
          if (run_q.size() != 0) begin
            r = run_q.pop_front();
            check("run_ch", 32'(bus.ch_sel), 32'(r.ch));
            check("run_fic_inj", 32'(fi_seen), 32'(r.fi));
            check("run_tpg_en_cycles", 32'(en_cnt), 32'(r.npat));
            check("run_rst_cycles", 32'(rcnt), 32'(RST_CYC));
            check("run_tpg_rst_cycles", 32'(trcnt), 32'(RST_CYC));
            exp_wlen = r.wlen;
          end
          cur_fi  = fi_seen;
          en_cnt  = 0; rcnt = 0; trcnt = 0;
          fi_seen = 1'b0;
          pending = 1'b1;
          wcnt    = 0;
          ora_cnt = ora_on ? ORA_LAT : 0;
        end else if (ora_cnt > 0) begin
          ora_cnt--;
          if (ora_cnt == 0) begin
            bus.ora_valid = 1'b1;
            bus.ora_pass  = cur_fi ? 1'b0 : ch_good[bus.ch_sel];
          end
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("result_expected", 32'(res_q.size() != 0), 32'd1);
        if (res_q.size() != 0) begin
          e = res_q.pop_front();
          check("pass_vec", 32'(bus.pass_vec), 32'(e.pass));
          check("fi_ok_vec", 32'(bus.fi_ok_vec), 32'(e.fi_ok));
        end
      end
    end
  end

  // Main directed sequence.
  initial begin
    int  d0;
    bit  found;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.mode_fi   = 1'b0;
    bus.pat_count = '0;
    repeat (3) @(negedge clk);
    check("rst_cut_rst", 32'(bus.cut_rst), 32'd1);
    check("rst_tpg_rst", 32'(bus.tpg_rst), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_tpg_en", 32'(bus.tpg_en), 32'd0);
    check("rst_ora_cmp", 32'(bus.ora_cmp), 32'd0);
    check("rst_ch_sel", 32'(bus.ch_sel), 32'd0);
    check("rst_pass_vec", 32'(bus.pass_vec), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cut_rst", 32'(bus.cut_rst), 32'd0);
    check("idle_tpg_rst", 32'(bus.tpg_rst), 32'd0);

    // functional pass, channel 2 fails
    ch_good = 4'b1011; ora_on = 1'b1; end_at = 0;
    push_runs(1'b0, 8, ORA_LAT + 1);
    res_q.push_back('{pass: 4'b1011, fi_ok: 4'b0000});
    d0 = done_cnt;
    start_test(1'b0, 8);
    finish_test("basic", d0);

    // fault-injection self-check
    ch_good = 4'b1111;
    push_runs(1'b1, 8, ORA_LAT + 1);
    res_q.push_back('{pass: 4'b1111, fi_ok: 4'b1111});
    d0 = done_cnt;
    start_test(1'b1, 8);
    finish_test("fi", d0);

    // early termination by tpg_end on the 5th pattern
    end_at = 5;
    push_runs(1'b0, 5, ORA_LAT + 1);
    res_q.push_back('{pass: 4'b1111, fi_ok: 4'b0000});
    d0 = done_cnt;
    start_test(1'b0, 100);
    finish_test("tpg_end", d0);

    // pat_count of zero runs one pattern
    end_at = 0;
    push_runs(1'b0, 1, ORA_LAT + 1);
    res_q.push_back('{pass: 4'b1111, fi_ok: 4'b0000});
    d0 = done_cnt;
    start_test(1'b0, 0);
    finish_test("pat_zero", d0);

    // ORA never answers: every WAIT times out
    ora_on = 1'b0;
    push_runs(1'b0, 8, int'(TO_CYC) + 1);
    res_q.push_back('{pass: 4'b0000, fi_ok: 4'b0000});
    d0 = done_cnt;
    start_test(1'b0, 8);
    finish_test("timeout", d0);

    // reset during RUN of channel 2, then restart
    ora_on = 1'b1; ch_good = 4'b1011;
    run_q.push_back('{ch: 0, fi: 1'b0, npat: 8, wlen: ORA_LAT + 1});
    run_q.push_back('{ch: 1, fi: 1'b0, npat: 8, wlen: ORA_LAT + 1});
    start_test(1'b0, 8);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.ch_sel == 2'd2 && bus.tpg_en) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_ch2_run", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_cut_rst", 32'(bus.cut_rst), 32'd1);
    check("abort_tpg_rst", 32'(bus.tpg_rst), 32'd1);
    check("abort_tpg_en", 32'(bus.tpg_en), 32'd0);
    check("abort_pass_vec", 32'(bus.pass_vec), 32'd0);
    check("abort_fi_ok_vec", 32'(bus.fi_ok_vec), 32'd0);
    check("abort_runs_left", 32'(run_q.size()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    push_runs(1'b0, 8, ORA_LAT + 1);
    res_q.push_back('{pass: 4'b1011, fi_ok: 4'b0000});
    d0 = done_cnt;
    start_test(1'b0, 8);
    finish_test("restart", d0);

    // start mid-test and in the DONE cycle are ignored
    push_runs(1'b0, 8, ORA_LAT + 1);
    res_q.push_back('{pass: 4'b1011, fi_ok: 4'b0000});
    d0 = done_cnt;
    start_test(1'b0, 8);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.ch_sel == 2'd1 && bus.tpg_en) begin
        found = 1'b1;
        break;
      end
    end
    check("busy_start_reached", 32'(found), 32'd1);
    bus.start = 1'b1; bus.mode_fi = 1'b1; bus.pat_count = CNT_W'(3);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(found);
    check("ign_done_seen", 32'(found), 32'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_start_busy", 32'(bus.busy), 32'd0);
    check("done_start_cut_rst", 32'(bus.cut_rst), 32'd0);
    repeat (4) @(negedge clk);
    check("ign_idle", 32'(bus.busy), 32'd0);
    check("ign_done_count", 32'(done_cnt - d0), 32'd1);
    check("ign_runs_left", 32'(run_q.size()), 32'd0);
    check("ign_pass_hold", 32'(bus.pass_vec), 32'h0000000b);
    check("ign_fi_ok_hold", 32'(bus.fi_ok_vec), 32'd0);

    check("no_stray_fic_inj", 32'(stray_fi), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
